sram_mem_ctrl: RTL
==================

// Module: sram_mem_ctrl
// PURPOSE
//  Sequences MEM-stage load/store requests onto an external 16-bit asynchronous SRAM.
//  - Each 32-bit word is split into two half-word accesses.
//  - Drives ready low while an access is in flight; the pipeline freezes all stage registers
//    (IF..MEM/WB) on ready=0.
//  - Sits between the MEM-stage ALU result/store value and the board SRAM pins;
//    rd_data feeds the MEM/WB register.
// PARAMETERS
//  ACCESS_CYC  2     cycles each half-word access is held on the SRAM pins (>=1)
//  SRAM_AW     18    SRAM half-word address width
//  BASE_ADDR   1024  byte address mapped to SRAM word 0
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, asynchronous, active-high
//  rd_en       in   1        MEM-stage load request (level, held until ready)
//  wr_en       in   1        MEM-stage store request (level, held until ready)
//  addr        in   32       byte address (ALU result)
//  st_val      in   32       store data
//  rd_data     out  32       load result; registered, valid from the DONE cycle onward
//  ready       out  1        1 = pipeline may advance; 0 = freeze
//  sram_addr   out  SRAM_AW  half-word address
//  sram_dq_o   out  16       write data to pad
//  sram_dq_oe  out  1        1 = drive pad (write phases)
//  sram_dq_i   in   16       read data from pad
//  sram_ce_n, sram_we_n, sram_oe_n  out  1  SRAM strobes, active-low
// BEHAVIOUR
//  States: IDLE, LO, HI, DONE. A 2-bit cycle counter cnt runs 0..ACCESS_CYC-1 within LO/HI.
//  - IDLE: on (rd_en|wr_en) -> LO, cnt=0. Latch op (wr_en wins if both are high), word address
//    waddr=(addr-BASE_ADDR)>>2, and st_val.
//  - LO: sram_addr={waddr,1'b0}. At cnt==ACCESS_CYC-1 -> HI, cnt=0; a read captures
//    sram_dq_i into rd_data[15:0].
//  - HI: sram_addr={waddr,1'b1}. At cnt==ACCESS_CYC-1 -> DONE; a read captures
//    sram_dq_i into rd_data[31:16].
//  - DONE: one cycle, ready=1 -> IDLE unconditionally. The request is still high that cycle
//    and is not re-sampled.
//  ready = (IDLE & ~rd_en & ~wr_en) | DONE; combinational from state and request.
//  Latency: request in cycle 0 -> ready=1 in cycle 2*ACCESS_CYC+1 (default: freeze 5 cycles).
//  Strobes:
//  - LO/HI: ce_n=0.
//  - Write phases: we_n=0, dq_oe=1, dq_o=latched half (low half in LO, high half in HI).
//  - Read phases: oe_n=0.
//  - IDLE/DONE: all strobes 1, dq_oe=0.
//  Address arithmetic is 32-bit unsigned; waddr is truncated to SRAM_AW-1 bits
//  (wrap-around, no fault). Below-base addresses wrap the same way.
//  rd_data holds its value until the next read's LO capture; writes never modify it.
//  Back-to-back requests: DONE->IDLE, then a new request starts LO the following cycle.
//  Reset (any time, including mid-access):
//  - state=IDLE, cnt=0, rd_data=0, sram_addr=0, dq_o=0, dq_oe=0, ce_n/we_n/oe_n=1.
//  - Any in-flight access is abandoned.
// CONFIGURATION
//  SRAM_STALL_CNT_EN defined:
//  - Adds output stall_cnt[31:0], reset 0, incremented each cycle ready==0.
//  - Saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Package mem_ctrl_pkg holds:
//  - enum mem_ctrl_state_t {IDLE, LO, HI, DONE}
//  - localparam HALF_W=16
//  - localparam WORD_W=32
//  Sub-module sram_access_timer: cnt register, load/clear inputs, last-cycle output.
//  FSM and strobe decode stay in sram_mem_ctrl.
// TESTING
//  1 Reset: rst=1 mid-LO -> next cycle IDLE, ce_n/we_n/oe_n=1, dq_oe=0, rd_data=0.
//    Idle with no request -> ready=1.
//  2 Store: wr_en, addr=1028, st_val=32'hDEAD_BEEF ->
//    - sram_addr=2, dq_o=16'hBEEF, we_n=0 for 2 cycles;
//    - then sram_addr=3, dq_o=16'hDEAD for 2 cycles;
//    - ready=0 for 5 cycles, then 1.
//  3 Load: SRAM model at half-addrs 2/3 returns 16'hBEEF/16'hDEAD, rd_en, addr=1028 ->
//    oe_n=0 for 4 cycles; rd_data=32'hDEAD_BEEF and ready=1 in cycle 5.
//  4 Back-to-back: store then load held across DONE -> exactly one access per request;
//    the load's LO starts 2 cycles after the store's DONE.
//  5 Simultaneous rd_en&wr_en -> write sequence only. rd_data unchanged.
//  6 SRAM_STALL_CNT_EN: two loads (ACCESS_CYC=2) -> stall_cnt=10.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the SRAM memory controller.
package mem_ctrl_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } mem_ctrl_state_t;

endpackage

// File: rtl/sram_access_timer.sv
// Per-phase cycle counter: counts 0..ACCESS_CYC-1 while a half-word is on the pins.
module sram_access_timer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic load_i,
    output logic last_o
);

    localparam logic [1:0] LastCnt = 2'(ACCESS_CYC - 1);

    logic [1:0] cnt_q, cnt_d;

    // Clear wins over advance; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two 16-bit async SRAM accesses.
// Optional build macro SRAM_STALL_CNT_EN adds a saturating freeze-cycle counter (stall_cnt).
module sram_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ACCESS_CYC = 2,
    parameter int unsigned SRAM_AW    = 18,
    parameter int unsigned BASE_ADDR  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   st_val,
    output logic [WORD_W-1:0]   rd_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [HALF_W-1:0]   sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [HALF_W-1:0]   sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_we_n,
    output logic                sram_oe_n
`ifdef SRAM_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned WAW = SRAM_AW - 1;

    mem_ctrl_state_t state_q, state_d;
    logic [WAW-1:0]    waddr_q, waddr_d;
    logic [WORD_W-1:0] st_val_q, st_val_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              wr_q, wr_d;
    logic              req;
    logic              last;
    logic              tmr_load, tmr_clear;

    assign req = rd_en | wr_en;

    sram_access_timer #(
        .ACCESS_CYC (ACCESS_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tmr_clear),
        .load_i  (tmr_load),
        .last_o  (last)
    );

    // Timer advances inside a phase and restarts at each phase boundary.
    always_comb begin
        tmr_load  = ((state_q == LO) || (state_q == HI)) && !last;
        tmr_clear = !tmr_load;
    end

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        st_val_d  = st_val_q;
        wr_d      = wr_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = LO;
                    wr_d     = wr_en;
                    // 32-bit wrap, then truncate to the SRAM word space.
                    waddr_d  = WAW'((addr - BASE_ADDR) >> 2);
                    st_val_d = st_val;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    if (!wr_q) begin
                        rd_data_d[HALF_W-1:0] = sram_dq_i;
                    end
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rd_data_d[WORD_W-1:HALF_W] = sram_dq_i;
                    end
                end
            end
            DONE: begin
                // Request is still high here but belongs to the finished access.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            st_val_q  <= '0;
            wr_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            st_val_q  <= st_val_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Pin and handshake decode from the current state.
    always_comb begin
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_ce_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        unique case (state_q)
            IDLE: ready = !req;
            LO: begin
                sram_addr = {waddr_q, 1'b0};
                sram_ce_n = 1'b0;
                if (wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = st_val_q[HALF_W-1:0];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            HI: begin
                sram_addr = {waddr_q, 1'b1};
                sram_ce_n = 1'b0;
                if (wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = st_val_q[WORD_W-1:HALF_W];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign rd_data = rd_data_q;

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count freeze cycles, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // No stall instrumentation in this build.
`endif

endmodule
